// File: rtl/irq_decoder_x2_o4_pkg.sv
// irq_decoder_x2_o4_pkg: shared widths, limits and state encoding for the interrupt decoder
package irq_decoder_x2_o4_pkg;
  localparam int VEC_W = 2;
  localparam int N_SRC = 4;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2, CLEAR = 2'd3} state_t;
endpackage

// File: rtl/irq_decoder_x2_o4_dec.sv
// dec_x2_o4: combinational binary-to-one-hot decode of the latched vector
module dec_x2_o4
  import irq_decoder_x2_o4_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic [N_SRC-1:0] onehot
);
  always_comb onehot = N_SRC'(1) << vec;
endmodule

// File: rtl/irq_decoder_x2_o4.sv
// irq_decoder_x2_o4: offers the highest pending request to the CPU and tracks its service
module irq_decoder_x2_o4
  import irq_decoder_x2_o4_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [VEC_W-1:0] i_addr,
  input  logic             i_zero,
  input  logic             i_ack,
  input  logic             i_eoi,
  output logic             o_irq,
  output logic [VEC_W-1:0] o_vector,
  output logic [N_SRC-1:0] o_grant,
  output logic [N_SRC-1:0] o_clr,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_count
);
  state_t state_q, state_d;
  logic [VEC_W-1:0] vec_d;
  logic [N_SRC-1:0] grant_d, clr_d, onehot;
  logic [CNT_W-1:0] cnt_d;
  dec_x2_o4 u_dec (.vec(o_vector), .onehot(onehot));
  always_comb begin
    state_d = state_q;
    vec_d   = o_vector;
    grant_d = o_grant;
    clr_d   = '0;
    cnt_d   = o_count;
    case (state_q)
      IDLE: begin
        state_d = i_zero ? IDLE : REQ;
        vec_d   = i_zero ? o_vector : i_addr;
      end
      REQ: begin
        state_d = i_ack ? SERVICE : (i_zero ? IDLE : REQ);
        vec_d   = (!i_ack && !i_zero && i_addr > o_vector) ? i_addr : o_vector;
        grant_d = i_ack ? onehot : o_grant;
      end
      SERVICE: begin
        state_d = i_eoi ? CLEAR : SERVICE;
        clr_d   = i_eoi ? onehot : '0;
        grant_d = i_eoi ? '0 : o_grant;
        cnt_d   = (i_eoi && o_count != CNT_MAX) ? o_count + 1'b1 : o_count;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      o_irq    <= 1'b0;
      o_vector <= '0;
      o_grant  <= '0;
      o_clr    <= '0;
      o_busy   <= 1'b0;
      o_count  <= '0;
    end else begin
      state_q  <= state_d;
      o_irq    <= state_d == REQ;
      o_vector <= vec_d;
      o_grant  <= grant_d;
      o_clr    <= clr_d;
      o_busy   <= state_d != IDLE;
      o_count  <= cnt_d;
    end
  end
endmodule

// File: tb/tb_irq_decoder_x2_o4.sv
// tb_irq_decoder_x2_o4: scoreboard bench driving directed vectors into irq_decoder_x2_o4
module tb_irq_decoder_x2_o4;
  typedef struct packed {
    logic       irq;
    logic [1:0] vec;
    logic [3:0] grant;
    logic [3:0] clr;
    logic       busy;
    logic [7:0] cnt;
  } snap_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] addr = 2'd0;
  logic zero = 1'b1;
  logic ack = 1'b0;
  logic eoi = 1'b0;
  logic irq, busy;
  logic [1:0] vec;
  logic [3:0] grant, clr;
  logic [7:0] cnt;
  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;
  irq_decoder_x2_o4 dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_zero(zero), .i_ack(ack), .i_eoi(eoi),
    .o_irq(irq), .o_vector(vec), .o_grant(grant), .o_clr(clr), .o_busy(busy), .o_count(cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      snap_t e, a;
      e = exp_q.pop_front();
      a = '{irq, vec, grant, clr, busy, cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL check %0d: got irq=%b vec=%b grant=%b clr=%b busy=%b cnt=%0d, want irq=%b vec=%b grant=%b clr=%b busy=%b cnt=%0d",
                 checks, a.irq, a.vec, a.grant, a.clr, a.busy, a.cnt, e.irq, e.vec, e.grant, e.clr, e.busy, e.cnt);
      end
    end
  end
  task automatic cyc(input logic r, z, input logic [1:0] a, input logic k, e,
                     input logic x_irq, input logic [1:0] x_vec, input logic [3:0] x_gr, x_cl,
                     input logic x_busy, input logic [7:0] x_cnt);
    @(negedge clk);
    rst = r; zero = z; addr = a; ack = k; eoi = e;
    exp_q.push_back('{x_irq, x_vec, x_gr, x_cl, x_busy, x_cnt});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    cyc(1, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    cyc(1, 0, 3, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0);
    cyc(0, 0, 2, 0, 0, 1, 2, 4'b0000, 4'b0000, 1, 0);
    cyc(0, 0, 2, 1, 0, 0, 2, 4'b0100, 4'b0000, 1, 0);
    cyc(0, 0, 2, 0, 1, 0, 2, 4'b0000, 4'b0100, 1, 1);
    cyc(0, 1, 0, 0, 0, 0, 2, 4'b0000, 4'b0000, 0, 1);
    cyc(0, 1, 0, 0, 1, 0, 2, 4'b0000, 4'b0000, 0, 1);
    cyc(0, 1, 0, 1, 0, 0, 2, 4'b0000, 4'b0000, 0, 1);
    cyc(0, 0, 1, 0, 0, 1, 1, 4'b0000, 4'b0000, 1, 1);
    cyc(0, 0, 1, 0, 1, 1, 1, 4'b0000, 4'b0000, 1, 1);
    cyc(0, 0, 3, 0, 0, 1, 3, 4'b0000, 4'b0000, 1, 1);
    cyc(0, 0, 0, 0, 0, 1, 3, 4'b0000, 4'b0000, 1, 1);
    cyc(0, 0, 0, 1, 0, 0, 3, 4'b1000, 4'b0000, 1, 1);
    cyc(0, 0, 2, 1, 0, 0, 3, 4'b1000, 4'b0000, 1, 1);
    cyc(0, 1, 1, 0, 0, 0, 3, 4'b1000, 4'b0000, 1, 1);
    cyc(0, 0, 0, 0, 1, 0, 3, 4'b0000, 4'b1000, 1, 2);
    cyc(0, 1, 0, 0, 0, 0, 3, 4'b0000, 4'b0000, 0, 2);
    cyc(0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000, 1, 2);
    cyc(0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 2);
    cyc(0, 0, 1, 0, 0, 1, 1, 4'b0000, 4'b0000, 1, 2);
    cyc(0, 1, 0, 1, 0, 0, 1, 4'b0010, 4'b0000, 1, 2);
    cyc(1, 1, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    for (int k = 1; k <= 256; k++) begin
      cyc(0, 0, 0, 0, 0, 1, 0, 4'b0000, 4'b0000, 1, 8'(k - 1 > 255 ? 255 : k - 1));
      cyc(0, 0, 0, 1, 0, 0, 0, 4'b0001, 4'b0000, 1, 8'(k - 1 > 255 ? 255 : k - 1));
      cyc(0, 0, 0, 0, 1, 0, 0, 4'b0000, 4'b0001, 1, 8'(k > 255 ? 255 : k));
      cyc(0, 0, 3, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 8'(k > 255 ? 255 : k));
    end
    cyc(0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 255);
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_decoder_x2_o4.md
IRQ_DECODER_X2_O4 -- requirements
Module: irq_decoder_x2_o4

Interface
REQ-001 i_clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 i_rst  input  1  reset, synchronous, active-high.
REQ-003 i_addr  input  2  encoded index of the highest pending request source (3 = highest priority).
REQ-004 i_zero  input  1  high when no request source is pending; i_addr is don't-care while high.
REQ-005 i_ack  input  1  CPU accepts the outstanding interrupt; single-cycle pulse.
REQ-006 i_eoi  input  1  CPU end-of-interrupt; single-cycle pulse.
REQ-007 o_irq  output  1  interrupt request to CPU.
REQ-008 o_vector  output  2  latched index of the request being offered or serviced.
REQ-009 o_grant  output  4  one-hot in-service source, all zero when none.
REQ-010 o_clr  output  4  one-hot, one-cycle pulse clearing the serviced source's pending flag.
REQ-011 o_busy  output  1  high in any state other than IDLE.
REQ-012 o_count  output  8  number of completed services, saturating at 255.

Function
REQ-013 States SHALL be IDLE, REQ, SERVICE and CLEAR; all outputs SHALL be registered.
REQ-014 IDLE: if i_zero=0, the block SHALL latch i_addr into o_vector and enter REQ on the next edge; otherwise it SHALL remain in IDLE.
REQ-015 o_irq SHALL be 1 exactly while in REQ; first assertion is one cycle after i_zero=0 is sampled in IDLE.
REQ-016 REQ with i_ack=1: the block SHALL enter SERVICE and load o_grant with the one-hot decode of o_vector (bit n set for vector n).
REQ-017 REQ with i_ack=0, i_zero=0 and i_addr > o_vector: the block SHALL re-latch o_vector to i_addr (preemption before acknowledge) and stay in REQ.
REQ-018 REQ with i_ack=0 and i_zero=1 (source withdrawn): the block SHALL return to IDLE with o_vector unchanged.
REQ-019 i_ack=1 with i_zero=1 in the same REQ cycle: ack SHALL win and the block SHALL enter SERVICE with the current o_vector.
REQ-020 SERVICE: the block SHALL ignore i_addr, i_zero and i_ack and hold o_grant constant.
REQ-021 SERVICE with i_eoi=1: the block SHALL enter CLEAR, drive o_clr = decode(o_vector) for that single cycle, clear o_grant to 0000, and increment o_count unless it is 255.
REQ-022 CLEAR SHALL last exactly one cycle and return unconditionally to IDLE, with o_clr back to 0000; a new request SHALL be sampled no earlier than IDLE.
REQ-023 i_ack outside REQ and i_eoi outside SERVICE SHALL have no effect.
REQ-024 o_grant and o_clr SHALL never have more than one bit set.

Reset
REQ-025 With i_rst=1 at an edge, the block SHALL enter IDLE with o_irq=0, o_vector=00, o_grant=0000, o_clr=0000, o_busy=0 and o_count=0, regardless of the current state.
REQ-026 Reset SHALL take priority over every other input in the same cycle, including i_ack and i_eoi.

Structure
REQ-027 The state encoding (2 bits), the vector width (2), the source count (4) and the counter maximum (255) SHALL be defined in a shared package.
REQ-028 The one-hot decode SHALL be a single combinational sub-module dec_x2_o4, instantiated once and shared by the o_grant and o_clr paths.

Verification
REQ-029 Basic service: from reset, drive i_zero=0 and i_addr=10. Required: o_irq=1 next cycle. Pulse i_ack. Required: o_grant=0100. Pulse i_eoi. Required: o_clr=0100 for exactly one cycle, then o_grant=0000, o_count=1, back in IDLE.
REQ-030 Preemption: in REQ with o_vector=01, drive i_addr=11. Required: o_vector=11. Then drive i_addr=00. Required: o_vector stays 11. Ack. Required: o_grant=1000.
REQ-031 Withdrawal and tie: in REQ, set i_zero=1 alone. Required: IDLE next cycle, o_irq=0. Repeat with i_zero=1 and i_ack=1 together. Required: SERVICE entered.
REQ-032 Ignored strobes: i_eoi in IDLE/REQ and i_ack in SERVICE. Required: no state change, o_clr=0000, o_count unchanged.
REQ-033 Reset mid-SERVICE: with o_grant=0010, assert i_rst together with i_eoi. Required: all outputs at reset values and no o_clr pulse.
REQ-034 Saturation: complete 256 service cycles. Required: o_count reads 255 after the 255th service and after the 256th.
